rom_dl_router: RTL and testbench

- Parametrised successor to the fixed ROM selector: routes the HPS/SD download byte stream into up to NUM_REGIONS on-chip ROM/PROM regions.
- Region bases come from a parameter table, not hard-coded compares.
- Registers the stream and emits one-hot write enables with region-local addresses.
- Counts and checks accepted bytes, and holds the game core in reset until the download completes plus a settle delay.

---
 rtl/rom_dl_router.sv | 168 ++++++++++++++++
 tb/tb_rom_dl_router.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_dl_router.sv
// rom_dl_router: routes the download byte stream into NUM_REGIONS on-chip
// ROM regions through a two-stage pipeline and holds the game core in reset
// until the download has drained plus RELEASE_DLY cycles.
// Optional feature macro: ROM_DL_CHECKSUM_EN (16-bit sum of accepted bytes).
module rom_dl_router #(
  parameter int unsigned NUM_REGIONS = 14,
  parameter int unsigned ADDR_W      = 25,
  parameter int unsigned LOCAL_AW    = 14,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {
    25'h24A20, 25'h24A00, 25'h24900, 25'h24800, 25'h24000,
    25'h20000, 25'h1C000, 25'h18000, 25'h14000, 25'h10000,
    25'h0C000, 25'h08000, 25'h04000, 25'h00000},
  parameter logic [ADDR_W-1:0] TOTAL_SIZE = 25'h24A40,
  parameter int unsigned RELEASE_DLY = 16
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   DL_ACTIVE,
  input  logic                   DL_WR,
  input  logic [ADDR_W-1:0]      DL_ADDR,
  input  logic [7:0]             DL_DATA,
  output logic [NUM_REGIONS-1:0] WR_EN,
  output logic [LOCAL_AW-1:0]    WR_ADDR,
  output logic [7:0]             WR_DATA,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERR,
  output logic [ADDR_W-1:0]      BYTE_CNT,
  output logic [15:0]            CHECKSUM,
  output logic                   CORE_RESET
);

  // Region bases plus the end-of-map bound, so region i spans BOUNDS[i]..BOUNDS[i+1]
  localparam logic [(NUM_REGIONS+1)*ADDR_W-1:0] BOUNDS = {TOTAL_SIZE, REGION_BASE};
  localparam int unsigned CNT_W = $clog2(RELEASE_DLY + 1);
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(RELEASE_DLY - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_HOLD, S_RUN} state_t;

  state_t              state;
  logic                drain_ph;
  logic [CNT_W-1:0]    hold_cnt;
  logic                s1_acc;
  logic [ADDR_W-1:0]   s1_addr;
  logic [7:0]          s1_data;
  logic [NUM_REGIONS-1:0] dec_hit;
  logic [ADDR_W-1:0]   dec_off;
  logic                dec_err;
  logic                load_start;

  assign load_start = DL_ACTIVE && (state == S_IDLE || state == S_HOLD || state == S_RUN);

  // Stage 1: capture the incoming byte and whether it was accepted
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_acc  <= 1'b0;
      s1_addr <= '0;
      s1_data <= '0;
    end else begin
      s1_acc  <= DL_WR && (state == S_LOAD);
      s1_addr <= DL_ADDR;
      s1_data <= DL_DATA;
    end
  end

  // Region decode of the stage-1 address against the base table
  always_comb begin
    dec_hit = '0;
    dec_off = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      if (s1_addr >= BOUNDS[i*ADDR_W +: ADDR_W] && s1_addr < BOUNDS[(i+1)*ADDR_W +: ADDR_W]) begin
        dec_hit[i] = 1'b1;
        dec_off    = s1_addr - BOUNDS[i*ADDR_W +: ADDR_W];
      end
    end
    dec_err = (dec_hit == '0) || ((dec_off >> LOCAL_AW) != '0);
  end

  // Stage 2: registered write port, byte counter and sticky error flag
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      WR_EN    <= '0;
      WR_ADDR  <= '0;
      WR_DATA  <= '0;
      ERR      <= 1'b0;
      BYTE_CNT <= '0;
    end else begin
      WR_EN <= (s1_acc && !dec_err) ? dec_hit : '0;
      if (s1_acc) begin
        WR_ADDR <= dec_off[LOCAL_AW-1:0];
        WR_DATA <= s1_data;
      end
      if (load_start) begin
        ERR      <= 1'b0;
        BYTE_CNT <= '0;
      end else if (s1_acc) begin
        if (dec_err) ERR <= 1'b1;
        if (BYTE_CNT != '1) BYTE_CNT <= BYTE_CNT + ADDR_W'(1);
      end
    end
  end

`ifdef ROM_DL_CHECKSUM_EN
  // Wrap-around sum of every accepted byte, out-of-range bytes included
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      CHECKSUM <= '0;
    end else if (load_start) begin
      CHECKSUM <= '0;
    end else if (s1_acc) begin
      CHECKSUM <= CHECKSUM + {8'h00, s1_data};
    end
  end
`else
  assign CHECKSUM = '0;
`endif

  // Download sequencing and core reset release
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= S_IDLE;
      drain_ph   <= 1'b0;
      hold_cnt   <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      CORE_RESET <= 1'b1;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE, S_RUN: begin
          if (DL_ACTIVE) begin
            state      <= S_LOAD;
            BUSY       <= 1'b1;
            CORE_RESET <= 1'b1;
          end
        end
        S_LOAD: begin
          if (!DL_ACTIVE) begin
            state    <= S_DRAIN;
            drain_ph <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (drain_ph) begin
            state    <= S_HOLD;
            hold_cnt <= HOLD_INIT;
          end else begin
            drain_ph <= 1'b1;
          end
        end
        S_HOLD: begin
          if (DL_ACTIVE) begin
            state <= S_LOAD;
          end else if (hold_cnt == '0) begin
            state      <= S_RUN;
            DONE       <= 1'b1;
            CORE_RESET <= 1'b0;
            BUSY       <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_dl_router.sv
// Directed self-checking bench for rom_dl_router with default parameters.
module tb_rom_dl_router;

`ifdef ROM_DL_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        DL_ACTIVE;
  logic        DL_WR;
  logic [24:0] DL_ADDR;
  logic [7:0]  DL_DATA;
  logic [13:0] WR_EN;
  logic [13:0] WR_ADDR;
  logic [7:0]  WR_DATA;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [24:0] BYTE_CNT;
  logic [15:0] CHECKSUM;
  logic        CORE_RESET;

  int checks = 0;
  int errors = 0;

  logic [24:0] va[8];
  logic [7:0]  vd[8];
  logic [13:0] vwe[8];
  logic [13:0] vwa[8];

  rom_dl_router dut (
    .CLK(CLK), .RESET_N(RESET_N), .DL_ACTIVE(DL_ACTIVE), .DL_WR(DL_WR),
    .DL_ADDR(DL_ADDR), .DL_DATA(DL_DATA), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .BYTE_CNT(BYTE_CNT), .CHECKSUM(CHECKSUM), .CORE_RESET(CORE_RESET)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives n back-to-back strobes; DL_ACTIVE falls with the last one
  task automatic stream(input int n);
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        DL_WR = 1'b1; DL_ADDR = va[i]; DL_DATA = vd[i];
      end else begin
        DL_WR = 1'b0;
      end
      if (i == n - 1) DL_ACTIVE = 1'b0;
      step();
      if (i >= 1) begin
        chk("wr_en", WR_EN, vwe[i-1]);
        chk("wr_addr", WR_ADDR, vwa[i-1]);
        chk("wr_data", WR_DATA, vd[i-1]);
      end
    end
  endtask

  // Entered one cycle after DRAIN entry; release expected 2+16 cycles after it
  task automatic finish_dl(input logic [24:0] exp_cnt, input logic [15:0] exp_sum);
    for (int c = 2; c <= 17; c++) begin
      step();
      chk("done_early", DONE, 64'd0);
      if (c == 2) chk("wr_en_drained", WR_EN, 64'd0);
    end
    chk("core_reset_hold", CORE_RESET, 64'd1);
    chk("busy_hold", BUSY, 64'd1);
    step();
    chk("done_pulse", DONE, 64'd1);
    chk("core_reset_release", CORE_RESET, 64'd0);
    chk("busy_run", BUSY, 64'd0);
    chk("byte_cnt", BYTE_CNT, exp_cnt);
    chk("checksum", CHECKSUM, exp_sum);
    chk("err_clean", ERR, 64'd0);
    step();
    chk("done_one_cycle", DONE, 64'd0);
    chk("core_reset_run", CORE_RESET, 64'd0);
  endtask

  initial begin
    RESET_N = 1'b0; DL_ACTIVE = 1'b0; DL_WR = 1'b0; DL_ADDR = '0; DL_DATA = '0;
    #12;
    chk("rst_wr_en", WR_EN, 64'd0);
    chk("rst_wr_addr", WR_ADDR, 64'd0);
    chk("rst_wr_data", WR_DATA, 64'd0);
    chk("rst_busy", BUSY, 64'd0);
    chk("rst_done", DONE, 64'd0);
    chk("rst_err", ERR, 64'd0);
    chk("rst_byte_cnt", BYTE_CNT, 64'd0);
    chk("rst_checksum", CHECKSUM, 64'd0);
    chk("rst_core_reset", CORE_RESET, 64'd1);
    step();
    RESET_N = 1'b1;
    step();

    // Strobe while idle is ignored
    DL_WR = 1'b1; DL_ADDR = 25'h100; DL_DATA = 8'h44;
    step();
    DL_WR = 1'b0;
    step();
    step();
    chk("idle_wr_en", WR_EN, 64'd0);
    chk("idle_byte_cnt", BYTE_CNT, 64'd0);

    // Download A: region boundaries across the map
    va[0] = 25'h03FFF; vd[0] = 8'hFF; vwe[0] = 14'h0001; vwa[0] = 14'h3FFF;
    va[1] = 25'h04000; vd[1] = 8'hFF; vwe[1] = 14'h0002; vwa[1] = 14'h0000;
    va[2] = 25'h24000; vd[2] = 8'h02; vwe[2] = 14'h0200; vwa[2] = 14'h0000;
    va[3] = 25'h24905; vd[3] = 8'hA5; vwe[3] = 14'h0800; vwa[3] = 14'h0005;
    va[4] = 25'h24A3F; vd[4] = 8'h3F; vwe[4] = 14'h2000; vwa[4] = 14'h001F;
    va[5] = 25'h24A1F; vd[5] = 8'h11; vwe[5] = 14'h1000; vwa[5] = 14'h001F;
    DL_ACTIVE = 1'b1;
    step();
    chk("load_busy", BUSY, 64'd1);
    chk("load_core_reset", CORE_RESET, 64'd1);
    stream(6);
    finish_dl(25'd6, CK ? 16'h02F5 : 16'h0000);

    // Download B: out-of-range byte, then restart during HOLD
    DL_ACTIVE = 1'b1;
    step();
    chk("b_busy", BUSY, 64'd1);
    chk("b_core_reset", CORE_RESET, 64'd1);
    chk("b_cnt_cleared", BYTE_CNT, 64'd0);
    chk("b_sum_cleared", CHECKSUM, 64'd0);
    DL_WR = 1'b1; DL_ADDR = 25'h30000; DL_DATA = 8'h77; DL_ACTIVE = 1'b0;
    step();
    DL_WR = 1'b0;
    step();
    chk("oor_wr_en", WR_EN, 64'd0);
    chk("oor_err", ERR, 64'd1);
    chk("oor_byte_cnt", BYTE_CNT, 64'd1);
    chk("oor_checksum", CHECKSUM, CK ? 64'h77 : 64'h0);
    step(); step(); step(); step();
    chk("err_sticky", ERR, 64'd1);
    chk("hold_no_done", DONE, 64'd0);
    DL_ACTIVE = 1'b1;
    step();
    chk("restart_done", DONE, 64'd0);
    chk("restart_err", ERR, 64'd0);
    chk("restart_cnt", BYTE_CNT, 64'd0);
    chk("restart_busy", BUSY, 64'd1);

    // Download C continues the restarted session
    va[0] = 25'h00000; vd[0] = 8'hFF; vwe[0] = 14'h0001; vwa[0] = 14'h0000;
    va[1] = 25'h00001; vd[1] = 8'hFF; vwe[1] = 14'h0001; vwa[1] = 14'h0001;
    va[2] = 25'h00002; vd[2] = 8'h02; vwe[2] = 14'h0001; vwa[2] = 14'h0002;
    stream(3);
    finish_dl(25'd3, CK ? 16'h0200 : 16'h0000);

    // Reset in the middle of a stream
    DL_ACTIVE = 1'b1;
    step();
    chk("rerun_core_reset", CORE_RESET, 64'd1);
    DL_WR = 1'b1; DL_ADDR = 25'h10; DL_DATA = 8'h33;
    step();
    DL_ADDR = 25'h11;
    step();
    chk("mid_wr_en", WR_EN, 64'd1);
    chk("mid_wr_addr", WR_ADDR, 64'h10);
    chk("mid_byte_cnt", BYTE_CNT, 64'd1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("async_wr_en", WR_EN, 64'd0);
    chk("async_core_reset", CORE_RESET, 64'd1);
    chk("async_byte_cnt", BYTE_CNT, 64'd0);
    chk("async_busy", BUSY, 64'd0);
    DL_WR = 1'b0; DL_ACTIVE = 1'b0;
    step();
    step();
    RESET_N = 1'b1;
    step();
    chk("post_rst_wr_en", WR_EN, 64'd0);

    // Download D: zero-length after reset
    DL_ACTIVE = 1'b1;
    step();
    DL_ACTIVE = 1'b0;
    step();
    step();
    finish_dl(25'd0, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
